// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP word and the
// default register-index width.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_CSTALL = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    localparam logic [31:0] NOP   = 32'd0;
    localparam int          REG_W = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_watchdog.sv
// Counts consecutive cache-stall cycles (saturating) and raises a sticky
// timeout once the count reaches MAX_STALL.
module stall_watchdog #(
    parameter int MAX_STALL = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cstall_i,
    output logic timeout_o
);

    localparam logic [15:0] MAX_C = 16'(MAX_STALL);

    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    always_comb begin
        cnt_d = '0;
        if (cstall_i) begin
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
        to_d = to_q | (cnt_q == MAX_C);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MAX_STALL = 255,
    parameter int REG_W     = pipe_hazard_ctrl_pkg::REG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             icache_stall_i,
    input  logic             dcache_stall_i,
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             branch_i,
    input  logic             jump_i,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             stall_timeout_o,
    output logic [31:0]      perf_stall_o,
    output logic [31:0]      perf_flush_o,
    output logic [31:0]      perf_lu_o
);

    import pipe_hazard_ctrl_pkg::*;

    state_e state_q, state_d;
    logic   pend_q, pend_d;
    logic   cstall, lu, redir, timeout;

    assign cstall = icache_stall_i | dcache_stall_i;
    assign lu     = idex_memread_i & (idex_rt_i != '0) &
                    ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));
    assign redir  = branch_i | jump_i;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (cstall && redir) begin
            pend_d = 1'b1;
        end
        case (state_q)
            ST_RUN: begin
                if (cstall) state_d = ST_CSTALL;
            end
            ST_CSTALL: begin
                if (!cstall) begin
                    if (pend_q) begin
                        state_d = ST_DRAIN;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                // A stall that pre-empts the drain flush must keep it owed.
                if (cstall) begin
                    state_d = ST_CSTALL;
                    pend_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        stall_o       = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (cstall) begin
            stall_o      = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (state_q == ST_DRAIN) begin
            ifid_flush_o = 1'b1;
        end else if (lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else if (redir) begin
            ifid_flush_o = 1'b1;
        end
    end

    stall_watchdog #(.MAX_STALL(MAX_STALL)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cstall_i  (cstall),
        .timeout_o (timeout)
    );

    assign stall_timeout_o = timeout & ~rst_i;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_lu_q;

    // Outside reset, flush and bubble strobes come only from real events.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_lu_q    <= '0;
        end else begin
            if (cstall)        perf_stall_q <= perf_stall_q + 32'd1;
            if (ifid_flush_o)  perf_flush_q <= perf_flush_q + 32'd1;
            if (idex_bubble_o) perf_lu_q    <= perf_lu_q + 32'd1;
        end
    end

    assign perf_stall_o = rst_i ? '0 : perf_stall_q;
    assign perf_flush_o = rst_i ? '0 : perf_flush_q;
    assign perf_lu_o    = rst_i ? '0 : perf_lu_q;
`else
    assign perf_stall_o = '0;
    assign perf_flush_o = '0;
    assign perf_lu_o    = '0;
`endif

endmodule
